i2c_master_byte_ctrl: RTL
=========================

Name: i2c_master_byte_ctrl

Overview:
Byte-level I2C master sequencer placed directly upstream of the bit-level master PHY. It accepts one byte command per handshake: optional START, then WRITE or READ of 8 bits plus the ACK bit, then optional STOP. It expands each command into a sequence of single-bit PHY commands (START/STOP/WRITE/READ from i2c_pkg) and returns read data, the received ACK, and arbitration status.

Parameters:
WAIT_FREE, 1, 1 = a START from idle is held off while phy_bus_busy_i=1 and this master does not own the bus; 0 = issue it immediately.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
cmd_valid_i  in  1  byte command valid
cmd_ready_o  out  1  controller idle, command accepted when valid&ready
cmd_start_i  in  1  prefix the transfer with START (repeated START if bus owned)
cmd_write_i  in  1  write wr_data_i, then read the slave ACK
cmd_read_i  in  1  read a byte, then drive cmd_ack_i
cmd_stop_i  in  1  finish with STOP
cmd_ack_i  in  1  ACK bit driven after a read (0=ACK, 1=NACK)
wr_data_i  in  8  byte to write, sent MSB first
rd_data_o  out  8  byte read, MSB first
rx_ack_o  out  1  ACK bit sampled from the slave after a write
done_o  out  1  one-cycle pulse when the command completes or aborts
arb_lost_o  out  1  qualifies done_o: the command aborted on arbitration loss
bus_owned_o  out  1  START issued and no STOP yet
phy_cmd_o  out  3  bit command to the PHY (NOP when idle)
phy_data_o  out  1  bit to write
phy_data_i  in  1  bit read by the PHY
phy_cmd_done_i  in  1  PHY bit command complete (1-cycle pulse)
phy_arb_lost_i  in  1  PHY arbitration-lost pulse
phy_bus_busy_i  in  1  bus busy (START seen, no STOP yet)

Behaviour:
- Reset values: cmd_ready_o=1, phy_cmd_o=NOP, phy_data_o=1, rd_data_o=0, rx_ack_o=1, done_o=0, arb_lost_o=0, bus_owned_o=0. The FSM goes to IDLE and the bit counter clears. Reset mid-transfer abandons the transfer with no STOP issued.
- States: IDLE, WAIT_BUS, START, DATA, ACK, STOP, DONE.
- IDLE: cmd_ready_o=1.
  - On accept, latch all cmd_* fields and wr_data_i into a shift register. cmd_ready_o drops the next cycle.
  - Next state: WAIT_BUS if start & WAIT_FREE & phy_bus_busy_i & ~bus_owned_o; else START if start; else DATA if read|write; else STOP if stop; else DONE (empty command).
- WAIT_BUS: hold phy_cmd_o=NOP until phy_bus_busy_i=0, then go to START.
- PHY handshake:
  - phy_cmd_o holds a non-NOP code until the phy_cmd_done_i pulse.
  - On the cycle after the pulse, phy_cmd_o=NOP for exactly one cycle before the next bit command.
  - phy_data_o is stable for the whole command.
- START: issue START. On done, set bus_owned_o=1, then go to DATA if read|write, else STOP if stop, else DONE.
- DATA: 8 bit commands, counter 7 down to 0.
  - Write: phy_data_o = shift[7].
  - Read: on each done, shift phy_data_i into the LSB.
  - After bit 0, go to ACK.
- ACK:
  - After a write: issue READ, latch rx_ack_o=phy_data_i.
  - After a read: issue WRITE with phy_data_o=cmd_ack_i, and load rd_data_o from the shift register.
  - Then go to STOP if stop, else DONE.
- STOP: issue STOP. On done, clear bus_owned_o, then go to DONE.
- DONE: done_o=1 for one cycle, arb_lost_o=0, return to IDLE (cmd_ready_o=1 on the next cycle).
- A write+read command (both set) is illegal: it is treated as a write.
- Arbitration loss: phy_arb_lost_i in any non-IDLE state (WAIT_BUS included) has priority over phy_cmd_done_i in the same cycle.
  - Drive phy_cmd_o=NOP the next cycle and clear bus_owned_o.
  - Pulse done_o with arb_lost_o=1 on that same cycle, then go to IDLE. No STOP is issued.
- phy_arb_lost_i in IDLE is ignored; only bus_owned_o is cleared.
- Latency: done_o is asserted exactly one cycle after the final phy_cmd_done_i.

Test Plan:
1. START+WRITE 0xA5, slave ACK=0 -> PHY sees START, then WRITE bits 1,0,1,0,0,1,0,1, then READ. Response: rx_ack_o=0, done_o one cycle after the last done, bus_owned_o=1.
2. READ with cmd_ack_i=1, PHY returns bits 0x3C, plus STOP -> 8 READs, then WRITE with phy_data_o=1, then STOP. Response: rd_data_o=0x3C, bus_owned_o=0, done_o pulse.
3. Repeated START while owned with phy_bus_busy_i=1, WAIT_FREE=1 -> START issued immediately, no WAIT_BUS stall.
4. START from idle with phy_bus_busy_i=1 for 50 cycles -> phy_cmd_o=NOP for those 50 cycles, START on the cycle after busy falls.
5. phy_arb_lost_i coincident with phy_cmd_done_i during write bit 3 -> next cycle: done_o=1, arb_lost_o=1, phy_cmd_o=NOP, bus_owned_o=0, no STOP issued.
6. rst_i asserted mid-read at bit 5 -> next cycle all outputs at reset values, cmd_ready_o=1. A following command executes normally.

Source files
------------

// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C master sequencer: expands START / WRITE / READ+ACK / STOP byte
// commands into single-bit PHY commands and returns read data, ACK and arbitration status.
module i2c_master_byte_ctrl #(
  parameter bit WAIT_FREE = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_start_i,
  input  logic       cmd_write_i,
  input  logic       cmd_read_i,
  input  logic       cmd_stop_i,
  input  logic       cmd_ack_i,
  input  logic [7:0] wr_data_i,
  output logic [7:0] rd_data_o,
  output logic       rx_ack_o,
  output logic       done_o,
  output logic       arb_lost_o,
  output logic       bus_owned_o,
  output logic [2:0] phy_cmd_o,
  output logic       phy_data_o,
  input  logic       phy_data_i,
  input  logic       phy_cmd_done_i,
  input  logic       phy_arb_lost_i,
  input  logic       phy_bus_busy_i
);

  localparam logic [2:0] PhyNop   = 3'd0;
  localparam logic [2:0] PhyStart = 3'd1;
  localparam logic [2:0] PhyStop  = 3'd2;
  localparam logic [2:0] PhyWrite = 3'd3;
  localparam logic [2:0] PhyRead  = 3'd4;

  typedef enum logic [2:0] {
    StIdle, StWaitBus, StStart, StData, StAck, StStop, StDone
  } state_e;

  state_e     r_state;
  logic       r_ready, r_wr, r_rd, r_stop, r_ack;
  logic [7:0] r_shift, r_rd_data;
  logic [2:0] r_cnt, r_phy_cmd;
  logic       r_phy_data, r_rx_ack, r_done, r_arb_lost, r_bus_owned;

  state_e     w_after_start;
  logic       w_arb_abort;

  assign w_after_start = (r_wr || r_rd) ? StData : (r_stop ? StStop : StDone);
  // DONE is excluded so an abort never re-pulses done_o on its own completion cycle.
  assign w_arb_abort   = phy_arb_lost_i && (r_state != StIdle) && (r_state != StDone);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_ready     <= 1'b1;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_stop      <= 1'b0;
      r_ack       <= 1'b0;
      r_shift     <= 8'h00;
      r_rd_data   <= 8'h00;
      r_cnt       <= 3'd0;
      r_phy_cmd   <= PhyNop;
      r_phy_data  <= 1'b1;
      r_rx_ack    <= 1'b1;
      r_done      <= 1'b0;
      r_arb_lost  <= 1'b0;
      r_bus_owned <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_arb_lost <= 1'b0;
      if (w_arb_abort) begin
        r_phy_cmd   <= PhyNop;
        r_bus_owned <= 1'b0;
        r_done      <= 1'b1;
        r_arb_lost  <= 1'b1;
        r_state     <= StDone;
      end else begin
        if (phy_arb_lost_i) r_bus_owned <= 1'b0;
        unique case (r_state)
          StIdle: begin
            if (cmd_valid_i && r_ready) begin
              r_ready <= 1'b0;
              r_wr    <= cmd_write_i;
              r_rd    <= cmd_read_i;
              r_stop  <= cmd_stop_i;
              r_ack   <= cmd_ack_i;
              r_shift <= wr_data_i;
              r_cnt   <= 3'd7;
              if (WAIT_FREE && cmd_start_i && phy_bus_busy_i && !r_bus_owned) begin
                r_state <= StWaitBus;
              end else if (cmd_start_i) begin
                r_state <= StStart;
              end else if (cmd_write_i || cmd_read_i) begin
                r_state <= StData;
              end else if (cmd_stop_i) begin
                r_state <= StStop;
              end else begin
                r_state <= StDone;
                r_done  <= 1'b1;
              end
            end
          end
          StWaitBus: begin
            // Issue START directly so it appears the cycle after the bus frees up.
            if (!phy_bus_busy_i) begin
              r_state    <= StStart;
              r_phy_cmd  <= PhyStart;
              r_phy_data <= 1'b1;
            end
          end
          StStart: begin
            if (r_phy_cmd == PhyNop) begin
              r_phy_cmd  <= PhyStart;
              r_phy_data <= 1'b1;
            end else if (phy_cmd_done_i) begin
              r_phy_cmd   <= PhyNop;
              r_bus_owned <= 1'b1;
              r_state     <= w_after_start;
              r_done      <= (w_after_start == StDone);
            end
          end
          StData: begin
            if (r_phy_cmd == PhyNop) begin
              r_phy_cmd  <= r_wr ? PhyWrite : PhyRead;
              r_phy_data <= r_wr ? r_shift[7] : 1'b1;
            end else if (phy_cmd_done_i) begin
              r_phy_cmd <= PhyNop;
              r_shift   <= {r_shift[6:0], r_wr ? 1'b0 : phy_data_i};
              if (r_cnt == 3'd0) r_state <= StAck;
              else               r_cnt   <= r_cnt - 3'd1;
            end
          end
          StAck: begin
            if (r_phy_cmd == PhyNop) begin
              r_phy_cmd  <= r_wr ? PhyRead : PhyWrite;
              r_phy_data <= r_wr ? 1'b1 : r_ack;
              if (!r_wr) r_rd_data <= r_shift;
            end else if (phy_cmd_done_i) begin
              r_phy_cmd <= PhyNop;
              if (r_wr) r_rx_ack <= phy_data_i;
              r_state <= r_stop ? StStop : StDone;
              r_done  <= !r_stop;
            end
          end
          StStop: begin
            if (r_phy_cmd == PhyNop) begin
              r_phy_cmd  <= PhyStop;
              r_phy_data <= 1'b1;
            end else if (phy_cmd_done_i) begin
              r_phy_cmd   <= PhyNop;
              r_bus_owned <= 1'b0;
              r_state     <= StDone;
              r_done      <= 1'b1;
            end
          end
          StDone: begin
            r_ready <= 1'b1;
            r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign cmd_ready_o = r_ready;
  assign rd_data_o   = r_rd_data;
  assign rx_ack_o    = r_rx_ack;
  assign done_o      = r_done;
  assign arb_lost_o  = r_arb_lost;
  assign bus_owned_o = r_bus_owned;
  assign phy_cmd_o   = r_phy_cmd;
  assign phy_data_o  = r_phy_data;

endmodule
